// File: rtl/imm_decode_stage.sv
// Registered RV32/RV64 immediate decoder with a valid/ready handshake and a one-entry skid buffer.
// Produces the immediate, its format code, the PC and the PC-relative target for each instruction.
module imm_decode_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_target,
   output logic [CNT_W-1:0] dbg_br_cnt
);

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_Z    = 3'd6;
   localparam logic [2:0] FMT_SH   = 3'd7;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] tgt;
   } entry_t;

   logic [6:0]      opc;
   logic [2:0]      funct3;
   logic [5:0]      shamt;
   logic [5:0]      shamt_w;
   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic            pc_rel;
   entry_t          dec;
   entry_t          m_q;
   entry_t          s_q;
   logic            m_valid;
   logic            s_valid;
   logic            accept;

   assign opc     = in_inst[6:0];
   assign funct3  = in_inst[14:12];
   assign shamt   = (XLEN == 64) ? in_inst[25:20] : {1'b0, in_inst[24:20]};
   assign shamt_w = {1'b0, in_inst[24:20]};

   // Immediate extraction and format classification
   always_comb begin
      dec_imm = '0;
      dec_fmt = FMT_NONE;
      pc_rel  = 1'b0;
      case (opc)
         OP_LOAD, OP_JALR: begin
            dec_fmt = FMT_I;
            dec_imm = XLEN'($signed(in_inst[31:20]));
         end
         OP_IMM: begin
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec_fmt = FMT_SH;
               dec_imm = XLEN'(shamt);
            end else begin
               dec_fmt = FMT_I;
               dec_imm = XLEN'($signed(in_inst[31:20]));
            end
         end
         OP_IMM32: begin
            if (XLEN == 64) begin
               if (funct3 == 3'b001 || funct3 == 3'b101) begin
                  dec_fmt = FMT_SH;
                  dec_imm = XLEN'(shamt_w);
               end else begin
                  dec_fmt = FMT_I;
                  dec_imm = XLEN'($signed(in_inst[31:20]));
               end
            end
         end
         OP_STORE: begin
            dec_fmt = FMT_S;
            dec_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
         end
         OP_BRANCH: begin
            dec_fmt = FMT_B;
            dec_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
            pc_rel  = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            dec_fmt = FMT_U;
            dec_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            pc_rel  = (opc == OP_AUIPC);
         end
         OP_JAL: begin
            dec_fmt = FMT_J;
            dec_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
            pc_rel  = 1'b1;
         end
         OP_SYSTEM: begin
            if (funct3[2]) begin
               dec_fmt = FMT_Z;
               dec_imm = XLEN'(in_inst[19:15]);
            end
         end
         default: ;
      endcase
   end

   assign dec = '{imm: dec_imm, fmt: dec_fmt, pc: in_pc,
                  tgt: pc_rel ? in_pc + dec_imm : '0};

   assign in_ready = !s_valid && !rst;
   assign accept   = in_valid && in_ready;

   // M feeds the outputs; S catches the one input accepted while M is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid    <= 1'b0;
         s_valid    <= 1'b0;
         m_q        <= '0;
         s_q        <= '0;
         dbg_br_cnt <= '0;
      end else begin
         if (m_valid && out_ready && m_q.fmt == FMT_B)
            dbg_br_cnt <= dbg_br_cnt + CNT_W'(1);
         if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
         end else if (!m_valid || out_ready) begin
            if (s_valid) begin
               m_q     <= s_q;
               m_valid <= 1'b1;
               s_valid <= 1'b0;
            end else begin
               m_valid <= accept;
               if (accept)
                  m_q <= dec;
            end
         end else if (accept) begin
            s_q     <= dec;
            s_valid <= 1'b1;
         end
      end
   end

   assign out_valid  = m_valid;
   assign out_imm    = m_q.imm;
   assign out_fmt    = m_q.fmt;
   assign out_pc     = m_q.pc;
   assign out_target = m_q.tgt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: an XLEN=32/CNT_W=4 and an XLEN=64/CNT_W=16 copy
// share one stimulus stream and are checked against a queue-based reference model.
module tb_imm_decode_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc;

   logic        a_in_ready, a_out_valid;
   logic [31:0] a_imm, a_pc, a_tgt;
   logic [2:0]  a_fmt;
   logic [3:0]  a_cnt;
   logic        b_in_ready, b_out_valid;
   logic [63:0] b_imm, b_pc, b_tgt;
   logic [2:0]  b_fmt;
   logic [15:0] b_cnt;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] inst;
      logic [63:0] pc;
   } exp_t;
   exp_t mq[$];
   int   m_cnt = 0;

   always #5 clk = ~clk;

   imm_decode_stage #(.XLEN(32), .CNT_W(4)) u_a (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_imm(a_imm), .out_fmt(a_fmt), .out_pc(a_pc), .out_target(a_tgt), .dbg_br_cnt(a_cnt));

   imm_decode_stage #(.XLEN(64), .CNT_W(16)) u_b (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_imm(b_imm), .out_fmt(b_fmt), .out_pc(b_pc), .out_target(b_tgt), .dbg_br_cnt(b_cnt));

   function automatic longint sx(longint v, int bits);
      if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
      return v;
   endfunction

   // Reference decode from the field rules, using integer arithmetic
   function automatic void ref_dec(input logic [31:0] w, input logic [63:0] pc, input int xlen,
                                   output logic [63:0] imm, output logic [2:0] fmt,
                                   output logic [63:0] tgt);
      longint v;
      bit     rel;
      int     op, f3;
      v = 0; rel = 0; fmt = 3'd0;
      op = int'(w[6:0]);
      f3 = int'(w[14:12]);
      case (op)
         'h03, 'h67: begin fmt = 3'd1; v = sx(longint'(w[31:20]), 12); end
         'h13, 'h1b: begin
            if (op == 'h1b && xlen == 32) fmt = 3'd0;
            else if (f3 == 1 || f3 == 5) begin
               fmt = 3'd7;
               v = (op == 'h13 && xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
            end else begin
               fmt = 3'd1; v = sx(longint'(w[31:20]), 12);
            end
         end
         'h23: begin fmt = 3'd2; v = sx(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12); end
         'h63: begin
            fmt = 3'd3; rel = 1;
            v = sx(longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                   + longint'(w[11:8]) * 2, 13);
         end
         'h37, 'h17: begin fmt = 3'd4; rel = (op == 'h17); v = sx(longint'(w[31:12]) * 4096, 32); end
         'h6f: begin
            fmt = 3'd5; rel = 1;
            v = sx(longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                   + longint'(w[30:21]) * 2, 21);
         end
         'h73: if (f3 >= 4) begin fmt = 3'd6; v = longint'(w[19:15]); end
         default: ;
      endcase
      imm = 64'(v);
      tgt = rel ? pc + imm : 64'd0;
      if (xlen == 32) begin
         imm = imm & 64'hFFFF_FFFF;
         tgt = tgt & 64'hFFFF_FFFF;
      end
   endfunction

   function automatic logic [31:0] rand_inst(input int force_op);
      logic [6:0]  ops [10] = '{7'h03, 7'h67, 7'h13, 7'h1b, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h73};
      logic [31:0] w;
      int          k;
      w = $urandom;
      k = $urandom_range(0, 10);
      if (force_op >= 0) w[6:0] = 7'(force_op);
      else if (k < 10) w[6:0] = ops[k];
      return w;
   endfunction

   // One clock: the model sees the same pre-edge inputs the DUT does
   task automatic tick();
      bit         acc, del;
      logic [63:0] ei, et;
      logic [2:0]  ef;
      acc = in_valid && !rst && (mq.size() < 2);
      del = out_ready && (mq.size() > 0);
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_cnt = 0;
      end else begin
         if (del) begin
            ref_dec(mq[0].inst, mq[0].pc, 64, ei, ef, et);
            if (ef == 3'd3) m_cnt++;
            void'(mq.pop_front());
         end
         if (flush) mq.delete();
         else if (acc) mq.push_back('{in_inst, in_pc});
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0;
      tick(); tick();
      n_cmp++;
      if ({a_out_valid, b_out_valid, a_fmt, b_fmt} !== 8'd0) begin
         n_err++; $display("FAIL reset_valid_fmt got %b%b %0d %0d exp 0", a_out_valid, b_out_valid, a_fmt, b_fmt);
      end
      n_cmp++;
      if ({a_imm, a_pc, a_tgt, b_imm, b_pc, b_tgt} !== '0) begin
         n_err++; $display("FAIL reset_data got a %h %h %h b %h %h %h exp 0", a_imm, a_pc, a_tgt, b_imm, b_pc, b_tgt);
      end
      n_cmp++;
      if ({a_cnt, b_cnt, a_in_ready, b_in_ready} !== '0) begin
         n_err++; $display("FAIL reset_cnt_ready got %0d %0d %b %b exp 0", a_cnt, b_cnt, a_in_ready, b_in_ready);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({a_in_ready, b_in_ready} !== 2'b11) begin
         n_err++; $display("FAIL reset_release_ready got %b%b exp 11", a_in_ready, b_in_ready);
      end
   endtask

   task automatic test_branch_single();
      in_valid = 1'b1; in_inst = 32'hFE000EE3; in_pc = 64'h100; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if ({a_out_valid, a_fmt, a_imm, a_tgt, a_pc} !== {1'b1, 3'd3, 32'hFFFFFFFC, 32'h000000FC, 32'h100}) begin
         n_err++; $display("FAIL branch32 got v%b f%0d imm %h tgt %h pc %h exp v1 f3 fffffffc fc 100",
                           a_out_valid, a_fmt, a_imm, a_tgt, a_pc);
      end
      n_cmp++;
      if ({b_out_valid, b_fmt, b_imm, b_tgt} !== {1'b1, 3'd3, 64'hFFFFFFFFFFFFFFFC, 64'hFC}) begin
         n_err++; $display("FAIL branch64 got v%b f%0d imm %h tgt %h exp v1 f3 fffffffffffffffc fc",
                           b_out_valid, b_fmt, b_imm, b_tgt);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++;
      if ({a_out_valid, b_out_valid, a_cnt, b_cnt} !== {2'b00, 4'd1, 16'd1}) begin
         n_err++; $display("FAIL branch_count got v%b%b cnt %0d %0d exp v00 cnt 1 1",
                           a_out_valid, b_out_valid, a_cnt, b_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] insts [3] = '{32'hFFF00093, 32'h123450B7, 32'h0080006F};
      logic [63:0] pcs   [3] = '{64'h1F8, 64'h1FC, 64'h200};
      logic [2:0]  fmts  [3] = '{3'd1, 3'd4, 3'd5};
      logic [63:0] imms  [3] = '{64'hFFFFFFFFFFFFFFFF, 64'h12345000, 64'h8};
      logic [63:0] tgts  [3] = '{64'h0, 64'h0, 64'h208};
      logic [63:0] e;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_inst = insts[i]; in_pc = pcs[i];
         tick();
         e = imms[i];
         n_cmp++;
         if ({a_out_valid, a_in_ready, a_fmt, a_imm, a_pc, a_tgt} !==
             {1'b1, 1'b1, fmts[i], e[31:0], pcs[i][31:0], tgts[i][31:0]}) begin
            n_err++; $display("FAIL b2b32_%0d got v%b r%b f%0d imm %h pc %h tgt %h exp f%0d imm %h tgt %h",
                              i, a_out_valid, a_in_ready, a_fmt, a_imm, a_pc, a_tgt, fmts[i], e[31:0], tgts[i]);
         end
         n_cmp++;
         if ({b_out_valid, b_fmt, b_imm, b_pc, b_tgt} !== {1'b1, fmts[i], imms[i], pcs[i], tgts[i]}) begin
            n_err++; $display("FAIL b2b64_%0d got v%b f%0d imm %h pc %h tgt %h exp f%0d imm %h tgt %h",
                              i, b_out_valid, b_fmt, b_imm, b_pc, b_tgt, fmts[i], imms[i], tgts[i]);
         end
      end
      in_valid = 1'b0;
      tick();
      n_cmp++;
      if ({a_out_valid, b_out_valid} !== 2'b00) begin
         n_err++; $display("FAIL b2b_drain got %b%b exp 00", a_out_valid, b_out_valid);
      end
   endtask

   task automatic test_shift_csr();
      logic [31:0] insts [5] = '{32'h4030D093, 32'h3002D073, 32'h30029073, 32'h0230909B, 32'h02309093};
      logic [2:0]  fa    [5] = '{3'd7, 3'd6, 3'd0, 3'd0, 3'd7};
      logic [2:0]  fb    [5] = '{3'd7, 3'd6, 3'd0, 3'd7, 3'd7};
      logic [31:0] ia    [5] = '{32'd3, 32'd5, 32'd0, 32'd0, 32'd3};
      logic [63:0] ib    [5] = '{64'd3, 64'd5, 64'd0, 64'd3, 64'd35};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_inst = insts[i]; in_pc = 64'h300 + 64'(4 * i);
         tick();
         n_cmp++;
         if ({a_out_valid, a_fmt, a_imm, a_tgt} !== {1'b1, fa[i], ia[i], 32'h0}) begin
            n_err++; $display("FAIL shcsr32_%0d got v%b f%0d imm %h tgt %h exp f%0d imm %h",
                              i, a_out_valid, a_fmt, a_imm, a_tgt, fa[i], ia[i]);
         end
         n_cmp++;
         if ({b_out_valid, b_fmt, b_imm, b_tgt} !== {1'b1, fb[i], ib[i], 64'h0}) begin
            n_err++; $display("FAIL shcsr64_%0d got v%b f%0d imm %h tgt %h exp f%0d imm %h",
                              i, b_out_valid, b_fmt, b_imm, b_tgt, fb[i], ib[i]);
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      logic [31:0] w [3];
      logic [63:0] ei, et;
      logic [2:0]  ef;
      int          n_acc = 0;
      for (int i = 0; i < 3; i++) w[i] = rand_inst(-1);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_inst = w[i]; in_pc = 64'h1000 + 64'(4 * i);
         if (a_in_ready) n_acc++;
         tick();
         if (i == 1) begin
            n_cmp++;
            if ({a_in_ready, b_in_ready} !== 2'b00) begin
               n_err++; $display("FAIL bp_ready_drop got %b%b exp 00", a_in_ready, b_in_ready);
            end
         end
      end
      ref_dec(w[0], 64'h1000, 32, ei, ef, et);
      n_cmp++;
      if ({n_acc == 2, a_in_ready, a_out_valid, a_pc, a_imm, a_fmt} !== {1'b1, 1'b0, 1'b1, 32'h1000, ei[31:0], ef}) begin
         n_err++; $display("FAIL bp_stall got acc %0d r%b v%b pc %h imm %h f%0d exp acc 2 r0 v1 pc 1000 imm %h f%0d",
                           n_acc, a_in_ready, a_out_valid, a_pc, a_imm, a_fmt, ei[31:0], ef);
      end
      out_ready = 1'b1;
      tick();
      n_cmp++;
      if ({a_out_valid, a_in_ready, a_pc, b_pc} !== {1'b1, 1'b1, 32'h1004, 64'h1004}) begin
         n_err++; $display("FAIL bp_second got v%b r%b pc %h %h exp v1 r1 pc 1004", a_out_valid, a_in_ready, a_pc, b_pc);
      end
      tick();
      ref_dec(w[2], 64'h1008, 64, ei, ef, et);
      n_cmp++;
      if ({b_out_valid, b_pc, b_imm, b_fmt, b_tgt} !== {1'b1, 64'h1008, ei, ef, et}) begin
         n_err++; $display("FAIL bp_third got v%b pc %h imm %h f%0d tgt %h exp pc 1008 imm %h f%0d tgt %h",
                           b_out_valid, b_pc, b_imm, b_fmt, b_tgt, ei, ef, et);
      end
      in_valid = 1'b0;
      tick();
      n_cmp++;
      if ({a_out_valid, b_out_valid} !== 2'b00) begin
         n_err++; $display("FAIL bp_drain got %b%b exp 00", a_out_valid, b_out_valid);
      end
   endtask

   task automatic test_flush();
      int cnt_before;
      cnt_before = m_cnt;
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = rand_inst('h63); in_pc = 64'h2000;
      tick();
      in_inst = rand_inst(-1); in_pc = 64'h2004;
      tick();
      n_cmp++;
      if ({a_in_ready, a_out_valid, a_fmt} !== {1'b0, 1'b1, 3'd3}) begin
         n_err++; $display("FAIL flush_full got r%b v%b f%0d exp r0 v1 f3", a_in_ready, a_out_valid, a_fmt);
      end
      flush = 1'b1; out_ready = 1'b1; in_inst = rand_inst(-1); in_pc = 64'h2008;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_cmp++;
      if ({a_out_valid, b_out_valid, a_in_ready, b_in_ready} !== 4'b0011) begin
         n_err++; $display("FAIL flush_clear got v%b%b r%b%b exp v00 r11", a_out_valid, b_out_valid, a_in_ready, b_in_ready);
      end
      n_cmp++;
      if ({a_cnt, b_cnt} !== {4'(cnt_before + 1), 16'(cnt_before + 1)}) begin
         n_err++; $display("FAIL flush_count got %0d %0d exp %0d", a_cnt, b_cnt, cnt_before + 1);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({a_out_valid, b_out_valid} !== 2'b00) begin
            n_err++; $display("FAIL flush_ghost_%0d got v%b%b pc %h exp v00", i, a_out_valid, b_out_valid, a_pc);
         end
      end
   endtask

   task automatic test_counter_wrap();
      rst = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_valid = 1'b1; in_inst = rand_inst('h63); in_pc = 64'h4000 + 64'(4 * i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      n_cmp++;
      if ({a_cnt, b_cnt, a_out_valid} !== {4'd1, 16'd17, 1'b0}) begin
         n_err++; $display("FAIL cnt_wrap got %0d %0d v%b exp 1 17 v0", a_cnt, b_cnt, a_out_valid);
      end
   endtask

   task automatic test_random();
      logic [63:0] ei, et;
      logic [2:0]  ef;
      for (int c = 0; c < 600; c++) begin
         rst       = ($urandom_range(0, 63) == 0);
         flush     = ($urandom_range(0, 15) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         in_inst   = rand_inst(-1);
         in_pc     = {$urandom, $urandom};
         tick();
         n_cmp++;
         if ({a_out_valid, b_out_valid, a_in_ready, b_in_ready} !==
             {{2{mq.size() > 0}}, {2{!rst && mq.size() < 2}}}) begin
            n_err++; $display("FAIL rnd_hs_%0d got v%b%b r%b%b exp depth %0d", c,
                              a_out_valid, b_out_valid, a_in_ready, b_in_ready, mq.size());
         end
         n_cmp++;
         if ({a_cnt, b_cnt} !== {4'(m_cnt), 16'(m_cnt)}) begin
            n_err++; $display("FAIL rnd_cnt_%0d got %0d %0d exp %0d", c, a_cnt, b_cnt, m_cnt);
         end
         if (mq.size() > 0) begin
            ref_dec(mq[0].inst, mq[0].pc, 32, ei, ef, et);
            n_cmp++;
            if ({a_fmt, a_imm, a_pc, a_tgt} !== {ef, ei[31:0], mq[0].pc[31:0], et[31:0]}) begin
               n_err++; $display("FAIL rnd32_%0d inst %h got f%0d imm %h pc %h tgt %h exp f%0d imm %h tgt %h",
                                 c, mq[0].inst, a_fmt, a_imm, a_pc, a_tgt, ef, ei[31:0], et[31:0]);
            end
            ref_dec(mq[0].inst, mq[0].pc, 64, ei, ef, et);
            n_cmp++;
            if ({b_fmt, b_imm, b_pc, b_tgt} !== {ef, ei, mq[0].pc, et}) begin
               n_err++; $display("FAIL rnd64_%0d inst %h got f%0d imm %h pc %h tgt %h exp f%0d imm %h tgt %h",
                                 c, mq[0].inst, b_fmt, b_imm, b_pc, b_tgt, ef, ei, et);
            end
         end
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_branch_single();
      test_back_to_back();
      test_shift_csr();
      test_backpressure();
      test_flush();
      test_counter_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
